div_share_ctrl: RTL and testbench

- Sequences one shared iterative divider core between NUM_REQ execute pipes in the dual-issue back end.
- Each EX pipe presents a held request, and the controller arbitrates round-robin.
- It launches the core with a single-cycle start pulse, waits for completion and returns the 64-bit {remainder, quotient} result with a one-cycle done pulse.
- It handles divide-by-zero locally, reuses the last completed result when operands repeat, and aborts the core on flush or requester withdrawal.

---
 rtl/div_share_ctrl.sv | 169 ++++++++++++++++
 tb/tb_div_share_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one iterative divider core between NUM_REQ execute
// pipes. Requests are granted round-robin. Divide-by-zero and repeats of the
// most recently completed operands are answered locally. In-flight work is
// aborted on flush or when the owning pipe withdraws its request.
module div_share_ctrl #(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_data1,
  input  logic [NUM_REQ*32-1:0]  req_data2,
  input  logic [NUM_REQ-1:0]     req_signed,
  output logic [NUM_REQ-1:0]     resp_done,
  output logic [63:0]            resp_result,
  output logic                   busy,
  output logic                   div_start,
  output logic [31:0]            div_data1,
  output logic [31:0]            div_data2,
  output logic                   div_signed,
  output logic                   div_abort,
  input  logic                   div_done,
  input  logic [63:0]            div_result
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [31:0]   op_data1;
  logic [31:0]   op_data2;
  logic          op_signed;
  logic [63:0]   result_q;

  logic [31:0]   cache_data1;
  logic [31:0]   cache_data2;
  logic          cache_signed;
  logic [63:0]   cache_result;
  logic          cache_valid;

  logic [31:0]   data1_arr [NUM_REQ];
  logic [31:0]   data2_arr [NUM_REQ];

  logic          grant_found;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand_idx;
  logic [31:0]   sel_data1;
  logic [31:0]   sel_data2;
  logic          sel_signed;
  logic          cache_hit;
  logic          abort;
  logic          resp_fire;

  function automatic int wrap_idx(input int base, input int offset);
    return (base + offset) % NUM_REQ;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data1_arr[i] = req_data1[32*i +: 32];
    assign data2_arr[i] = req_data2[32*i +: 32];
  end

  // Round-robin search from rr_ptr; scanning downward lets the closest requester win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    sel_data1   = '0;
    sel_data2   = '0;
    sel_signed  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = IW'(wrap_idx(int'(rr_ptr), k));
      if (req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
        sel_data1   = data1_arr[cand_idx];
        sel_data2   = data2_arr[cand_idx];
        sel_signed  = req_signed[cand_idx];
      end
    end
  end

  assign cache_hit = cache_valid && (cache_data1 == sel_data1) &&
                     (cache_data2 == sel_data2) && (cache_signed == sel_signed);

  assign abort = ((state == ST_LAUNCH) || (state == ST_WAIT)) &&
                 (flush || !req_valid[owner]);

  assign resp_fire   = (state == ST_DONE) && !flush;
  assign resp_done   = resp_fire ? (NUM_REQ'(1) << owner) : '0;
  assign resp_result = resp_fire ? result_q : 64'd0;
  assign busy        = (state != ST_IDLE);
  assign div_start   = (state == ST_LAUNCH) && !abort;
  assign div_abort   = abort;
  assign div_data1   = op_data1;
  assign div_data2   = op_data2;
  assign div_signed  = op_signed;

  // Controller FSM together with operand, result, arbitration and cache storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      op_data1     <= '0;
      op_data2     <= '0;
      op_signed    <= 1'b0;
      result_q     <= '0;
      cache_data1  <= '0;
      cache_data2  <= '0;
      cache_signed <= 1'b0;
      cache_result <= '0;
      cache_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush && grant_found) begin
            owner     <= grant_idx;
            op_data1  <= sel_data1;
            op_data2  <= sel_data2;
            op_signed <= sel_signed;
            if (sel_data2 == 32'd0) begin
              result_q <= {sel_data1, 32'hFFFF_FFFF};
              state    <= ST_DONE;
            end else if (cache_hit) begin
              result_q <= cache_result;
              state    <= ST_DONE;
            end else begin
              state <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          state <= abort ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (div_done) begin
            result_q     <= div_result;
            cache_data1  <= op_data1;
            cache_data2  <= op_data2;
            cache_signed <= op_signed;
            cache_result <= div_result;
            cache_valid  <= 1'b1;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!flush) begin
            rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed testbench for div_share_ctrl with two pipes; the divider core is
// played by the bench, which supplies hand-computed core results.
module tb_div_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  req_valid;
  logic [63:0] req_data1;
  logic [63:0] req_data2;
  logic [1:0]  req_signed;
  logic [1:0]  resp_done;
  logic [63:0] resp_result;
  logic        busy;
  logic        div_start;
  logic [31:0] div_data1;
  logic [31:0] div_data2;
  logic        div_signed;
  logic        div_abort;
  logic        div_done;
  logic [63:0] div_result;

  int tests_run;
  int tests_failed;

  div_share_ctrl #(.NUM_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_data1(req_data1), .req_data2(req_data2),
    .req_signed(req_signed), .resp_done(resp_done), .resp_result(resp_result),
    .busy(busy), .div_start(div_start), .div_data1(div_data1),
    .div_data2(div_data2), .div_signed(div_signed), .div_abort(div_abort),
    .div_done(div_done), .div_result(div_result)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int pipe, input logic [31:0] d1,
                         input logic [31:0] d2, input logic sg);
    req_data1[pipe*32 +: 32] = d1;
    req_data2[pipe*32 +: 32] = d2;
    req_signed[pipe]         = sg;
    req_valid[pipe]          = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    div_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (resp_done !== 2'b00 || resp_result !== 64'd0) begin tests_failed++; $display("[TB] FAIL reset_resp: got %b/%h expected 00/0", resp_done, resp_result); end
    tests_run++; if (div_start !== 1'b0 || div_abort !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_core_ctl: got start %b abort %b expected 0/0", div_start, div_abort); end
    tests_run++; if (div_data1 !== 32'd0 || div_data2 !== 32'd0 || div_signed !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_core_data: got %h %h %b expected zeros", div_data1, div_data2, div_signed); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 32'd100, 32'd7, 1'b1);
    tick();
    tests_run++; if (div_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_start: got %b expected 1", div_start); end
    tests_run++; if (div_data1 !== 32'd100 || div_data2 !== 32'd7 || div_signed !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_operands: got %h %h %b expected 64 7 1", div_data1, div_data2, div_signed); end
    tick();
    tests_run++; if (div_start !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_wait: got start %b busy %b expected 0/1", div_start, busy); end
    repeat (3) tick();
    tests_run++; if (resp_done !== 2'b00) begin tests_failed++; $display("[TB] FAIL single_early_resp: got %b expected 00", resp_done); end
    div_done = 1'b1;
    div_result = {32'd2, 32'd14};
    tick();
    tests_run++; if (resp_done !== 2'b01) begin tests_failed++; $display("[TB] FAIL single_resp_done: got %b expected 01", resp_done); end
    tests_run++; if (resp_result !== {32'd2, 32'd14}) begin tests_failed++; $display("[TB] FAIL single_result: got %h expected %h", resp_result, {32'd2, 32'd14}); end
    div_done = 1'b0;
    req_valid = '0;
    tick();
    tests_run++; if (resp_done !== 2'b00 || resp_result !== 64'd0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_idle: got %b %h %b expected 00 0 0", resp_done, resp_result, busy); end
  endtask

  task automatic test_concurrent();
    do_reset();
    set_req(0, 32'd100, 32'd7, 1'b1);
    set_req(1, 32'hFFFF_FFF7, 32'd2, 1'b1);
    tick();
    tests_run++; if (div_data1 !== 32'd100) begin tests_failed++; $display("[TB] FAIL conc_first_grant: got %h expected 64", div_data1); end
    tick();
    div_done = 1'b1;
    div_result = {32'd2, 32'd14};
    tick();
    tests_run++; if (resp_done !== 2'b01) begin tests_failed++; $display("[TB] FAIL conc_resp0: got %b expected 01", resp_done); end
    div_done = 1'b0;
    req_valid[0] = 1'b0;
    tick();
    tests_run++; if (resp_done !== 2'b00 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL conc_gap: got %b busy %b expected 00/0", resp_done, busy); end
    tick();
    tests_run++; if (div_start !== 1'b1 || div_data1 !== 32'hFFFF_FFF7) begin tests_failed++; $display("[TB] FAIL conc_second_grant: got %b %h expected 1 fffffff7", div_start, div_data1); end
    tick();
    div_done = 1'b1;
    div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFC};
    tick();
    tests_run++; if (resp_done !== 2'b10 || resp_result !== {32'hFFFF_FFFF, 32'hFFFF_FFFC}) begin tests_failed++; $display("[TB] FAIL conc_resp1: got %b %h expected 10 fffffffffffffffc", resp_done, resp_result); end
    div_done = 1'b0;
    req_valid = '0;
    tick();
    set_req(0, 32'd55, 32'd5, 1'b0);
    set_req(1, 32'd66, 32'd6, 1'b0);
    tick();
    tests_run++; if (div_data1 !== 32'd55) begin tests_failed++; $display("[TB] FAIL conc_rr_wrap: got %h expected 37", div_data1); end
    flush = 1'b1;
    #1;
    tests_run++; if (div_start !== 1'b0 || div_abort !== 1'b1) begin tests_failed++; $display("[TB] FAIL launch_abort: got start %b abort %b expected 0/1", div_start, div_abort); end
    tick();
    flush = 1'b0;
    req_valid = '0;
    tests_run++; if (busy !== 1'b0 || resp_done !== 2'b00) begin tests_failed++; $display("[TB] FAIL launch_abort_idle: got busy %b resp %b expected 0/00", busy, resp_done); end
    tick();
  endtask

  task automatic test_div_zero();
    set_req(0, 32'h1234_5678, 32'd0, 1'b0);
    tick();
    tests_run++; if (div_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL dz_no_start: got %b expected 0", div_start); end
    tests_run++; if (resp_done !== 2'b01 || resp_result !== {32'h1234_5678, 32'hFFFF_FFFF}) begin tests_failed++; $display("[TB] FAIL dz_resp: got %b %h expected 01 12345678ffffffff", resp_done, resp_result); end
    req_valid = '0;
    tick();
    set_req(1, 32'hAAAA_0000, 32'd0, 1'b1);
    tick();
    flush = 1'b1;
    #1;
    tests_run++; if (resp_done !== 2'b00 || resp_result !== 64'd0) begin tests_failed++; $display("[TB] FAIL done_flush: got %b %h expected 00 0", resp_done, resp_result); end
    tick();
    flush = 1'b0;
    set_req(0, 32'h5555_0000, 32'd0, 1'b0);
    tick();
    tests_run++; if (resp_done !== 2'b10 || resp_result !== {32'hAAAA_0000, 32'hFFFF_FFFF}) begin tests_failed++; $display("[TB] FAIL dz_rr_kept: got %b %h expected 10 aaaa0000ffffffff", resp_done, resp_result); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_cache();
    set_req(1, 32'd1000, 32'd10, 1'b0);
    tick();
    tests_run++; if (div_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL cache_first_launch: got %b expected 1", div_start); end
    tick();
    div_done = 1'b1;
    div_result = {32'd0, 32'd100};
    tick();
    div_done = 1'b0;
    tests_run++; if (resp_done !== 2'b10 || resp_result !== {32'd0, 32'd100}) begin tests_failed++; $display("[TB] FAIL cache_first_resp: got %b %h expected 10 64", resp_done, resp_result); end
    tick();
    tests_run++; if (resp_done !== 2'b00 || div_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL cache_regrant: got %b %b expected 00 0", resp_done, div_start); end
    tick();
    tests_run++; if (resp_done !== 2'b10 || resp_result !== {32'd0, 32'd100} || div_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL cache_hit: got %b %h start %b expected 10 64 0", resp_done, resp_result, div_start); end
    req_signed[1] = 1'b1;
    tick();
    tick();
    tests_run++; if (div_start !== 1'b1 || div_signed !== 1'b1) begin tests_failed++; $display("[TB] FAIL cache_sign_miss: got %b %b expected 1 1", div_start, div_signed); end
    tick();
    div_done = 1'b1;
    div_result = {32'd0, 32'd100};
    tick();
    div_done = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_flush_wait();
    set_req(0, 32'd77, 32'd3, 1'b0);
    tick();
    tests_run++; if (div_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL fw_launch: got %b expected 1", div_start); end
    tick();
    tick();
    flush = 1'b1;
    #1;
    tests_run++; if (div_abort !== 1'b1) begin tests_failed++; $display("[TB] FAIL fw_abort: got %b expected 1", div_abort); end
    tick();
    flush = 1'b0;
    req_valid = '0;
    tests_run++; if (busy !== 1'b0 || resp_done !== 2'b00 || div_abort !== 1'b0) begin tests_failed++; $display("[TB] FAIL fw_idle: got %b %b %b expected 0 00 0", busy, resp_done, div_abort); end
    div_done = 1'b1;
    div_result = {32'd2, 32'd25};
    tick();
    div_done = 1'b0;
    tests_run++; if (busy !== 1'b0 || resp_done !== 2'b00) begin tests_failed++; $display("[TB] FAIL fw_stray_done: got %b %b expected 0 00", busy, resp_done); end
    set_req(0, 32'd77, 32'd3, 1'b0);
    tick();
    tests_run++; if (div_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL fw_relaunch: got %b expected 1", div_start); end
    tick();
    flush = 1'b1;
    div_done = 1'b1;
    div_result = {32'd2, 32'd25};
    tick();
    flush = 1'b0;
    div_done = 1'b0;
    tests_run++; if (busy !== 1'b0 || resp_done !== 2'b00) begin tests_failed++; $display("[TB] FAIL fw_flush_beats_done: got %b %b expected 0 00", busy, resp_done); end
    tick();
    tests_run++; if (div_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL fw_cache_untouched: got %b expected 1", div_start); end
    tick();
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    tests_run++; if (resp_done !== 2'b01 || resp_result !== {32'd2, 32'd25}) begin tests_failed++; $display("[TB] FAIL fw_final_resp: got %b %h expected 01 0000000200000019", resp_done, resp_result); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_withdraw_reset();
    set_req(1, 32'd40, 32'd6, 1'b0);
    tick();
    tick();
    req_valid[1] = 1'b0;
    #1;
    tests_run++; if (div_abort !== 1'b1) begin tests_failed++; $display("[TB] FAIL wd_abort: got %b expected 1", div_abort); end
    tick();
    tests_run++; if (busy !== 1'b0 || resp_done !== 2'b00 || div_abort !== 1'b0) begin tests_failed++; $display("[TB] FAIL wd_idle: got %b %b %b expected 0 00 0", busy, resp_done, div_abort); end
    set_req(0, 32'd8, 32'd3, 1'b0);
    tick();
    tick();
    tests_run++; if (busy !== 1'b1 || div_data1 !== 32'd8) begin tests_failed++; $display("[TB] FAIL rst_pre: got busy %b data %h expected 1 8", busy, div_data1); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0 || div_start !== 1'b0 || div_abort !== 1'b0 || resp_done !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_async_ctl: got %b %b %b %b expected all 0", busy, div_start, div_abort, resp_done); end
    tests_run++; if (div_data1 !== 32'd0 || div_data2 !== 32'd0 || resp_result !== 64'd0) begin tests_failed++; $display("[TB] FAIL rst_async_data: got %h %h %h expected 0", div_data1, div_data2, resp_result); end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    set_req(0, 32'd77, 32'd3, 1'b0);
    tick();
    tests_run++; if (div_start !== 1'b1 || resp_done !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_cache_cleared: got start %b resp %b expected 1 00", div_start, resp_done); end
    req_valid = '0;
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_final_idle: got %b expected 0", busy); end
  endtask

  // Test sequence.
  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    req_data1 = '0;
    req_data2 = '0;
    req_signed = '0;
    div_done = 1'b0;
    div_result = '0;
    test_reset();
    test_single();
    test_concurrent();
    test_div_zero();
    test_cache();
    test_flush_wait();
    test_withdraw_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
